traffic_phase_sequencer: RTL and testbench
==========================================

// Module: traffic_phase_sequencer
// PURPOSE
//  Parametrised N-approach traffic-light sequencer; next generation of the fixed 18-state controller.
//  Serves each light's green turn round-robin with cycle-exact, parameter-set phase durations.
//  Optional demand-based skipping of idle approaches, plus a flashing-yellow (night/fault) mode.
//  Sits under the system top; drives the per-light 2-bit lamp codes compared by the analyser.
// PARAMETERS
//  N_LIGHTS  4   number of approaches (2..8)
//  TMR_W     5   phase timer width; every T_* must be 1..2**TMR_W
//  T_ALLRED  1   cycles of all-red clearance before each green turn
//  T_RY      2   cycles of red+yellow preparation
//  T_GREEN   30  cycles of green
//  T_YG      2   cycles of yellow after green
//  T_FLASH   1   cycles per half-period of flash mode
//  SKIP_EN   0   1: approaches with demand=0 are skipped; 0: demand ignored
// PORTS
//  clk     in   1           rising-edge clock
//  reset   in   1           synchronous, active-high reset
//  go      in   1           1: run; 0: freeze state and timer (outputs hold)
//  flash   in   1           1: enter/stay in flashing-yellow mode
//  demand  in   N_LIGHTS    per-approach request, bit i = light i (used only if SKIP_EN=1)
//  sig     out  2*N_LIGHTS  lamp code of light i at sig[2i+1:2i]; G=00 YG=01 R=10 RY=11
//  active  out  $clog2(N)   index of light currently being served
//  turn_start out 1         one-cycle pulse in first cycle of each RY phase
// BEHAVIOUR
//  - States: ALLRED, RY, GREEN, YG, FLASH. Registers: state, idx (active), timer.
//  - Reset (sync, priority over all): state=ALLRED, idx=N_LIGHTS-1, timer=T_ALLRED-1, fl_ph=0;
//    sig = all R (10) from the cycle after reset sampled high; turn_start=0.
//  - sig/turn_start are a Moore decode of registered state: light idx shows RY/G/YG per state,
//    all others R; ALLRED = all R. No output depends combinationally on inputs.
//  - Timer loads T_x-1 on entry to state x; decrements each cycle with go=1; when timer==0 and
//    go=1 the state advances. Each state therefore lasts exactly T_x go-cycles.
//  - Order: ALLRED -> RY -> GREEN -> YG -> ALLRED. Next light chosen on ALLRED exit:
//    SKIP_EN=0: idx <= (idx+1) mod N_LIGHTS.
//    SKIP_EN=1: first j scanning (idx+1)...(idx+N) mod N with demand[j]=1 (idx itself last);
//    none set: stay in ALLRED, reload T_ALLRED-1, idx unchanged.
//  - demand sampled only in the ALLRED exit cycle; changes elsewhere have no effect.
//  - go=0: state, idx, timer, fl_ph held; turn_start forced 0 while frozen.
//  - flash=1 (priority over go): from any state, next edge enters FLASH, timer=T_FLASH-1, fl_ph=0.
//    In FLASH all lights show YG when fl_ph=0, R when fl_ph=1; fl_ph toggles when timer==0,
//    then timer reloads. go ignored in FLASH.
//  - flash=0 while in FLASH: next edge enters ALLRED, timer=T_ALLRED-1, idx unchanged, so
//    service resumes with the light after the interrupted one.
//  - Simultaneous reset and flash: reset wins. Reset mid-phase: abort immediately, no clearance.
//  - T_x=1: state lasts one go-cycle (timer loads 0). Timer never wraps; idx wraps N-1 -> 0.
// STRUCTURE
//  - traffic_pkg: lamp codes G/YG/R/RY, state enum, clog2 helper; shared with analyser/benches.
//  - Sub-module phase_timer (TMR_W): load value, load strobe, enable -> zero flag; no wrap.
//  - Next-light selection is a combinational round-robin scan in this module.
// TESTING
//  1 Defaults, go=1, 200 cycles after reset: light0 RY 2, G 30, YG 2; all-red 1 between turns;
//    full 4-light round = 140 cycles; turn_start pulses at RY entries only.
//  2 go=0 for 7 cycles mid-GREEN (cycle 10): sig unchanged, green ends 7 cycles late (37 total).
//  3 SKIP_EN=1, demand=4'b0100: only light 2 ever served; demand=0: sig stays all R, active fixed.
//  4 SKIP_EN=1, demand=4'b1010 while light 1 in GREEN: next served 3, then 1; lights 0, 2 never G.
//  5 flash=1 during light1 GREEN: next cycle all YG, alternating all R every cycle (T_FLASH=1);
//    flash=0: 1 cycle all R, then light 2 RY.
//  6 reset=1 mid-YG with flash=1: next cycle all R, active=N-1, then light 0 RY after 1 cycle.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase sequencer: lamp codes, phase
// states and a constant-evaluable clog2 used for index widths.
package traffic_pkg;

    localparam logic [1:0] LAMP_G  = 2'b00;
    localparam logic [1:0] LAMP_YG = 2'b01;
    localparam logic [1:0] LAMP_R  = 2'b10;
    localparam logic [1:0] LAMP_RY = 2'b11;

    typedef enum logic [2:0] {
        ST_ALLRED,
        ST_RY,
        ST_GREEN,
        ST_YG,
        ST_FLASH
    } state_t;

    // Width needed to hold values 0..value-1 (at least 1 bit for value >= 2).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counting phase timer: loads a value on strobe, decrements while
// enabled and stops at zero (never wraps). zero reflects the registered count.
module phase_timer #(
    parameter int TMR_W   = 5,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Load has priority over counting; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, restarted at the all-red clearance value on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= TMR_W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// N-approach traffic-light sequencer: round-robin green turns with
// parameter-set phase lengths, optional skipping of idle approaches and a
// flashing-yellow mode. All outputs decode registered state only.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int N_LIGHTS = 4,
    parameter int TMR_W    = 5,
    parameter int T_ALLRED = 1,
    parameter int T_RY     = 2,
    parameter int T_GREEN  = 30,
    parameter int T_YG     = 2,
    parameter int T_FLASH  = 1,
    parameter int SKIP_EN  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          go,
    input  logic                          flash,
    input  logic [N_LIGHTS-1:0]           demand,
    output logic [2*N_LIGHTS-1:0]         sig,
    output logic [clog2(N_LIGHTS)-1:0]    active,
    output logic                          turn_start
);

    localparam int IDX_W = clog2(N_LIGHTS);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               fl_ph_q, fl_ph_d;
    logic               turn_start_q, turn_start_d;

    logic               tmr_load;
    logic               tmr_en;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;

    logic [IDX_W-1:0]   rr_next;
    logic [IDX_W-1:0]   skip_next;
    logic               skip_found;
    logic [1:0]         lamp;

    phase_timer #(
        .TMR_W   (TMR_W),
        .RST_VAL (T_ALLRED - 1)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Candidate next lights: plain successor, and the first requesting light
    // scanning from the successor round to the current light itself.
    always_comb begin
        int j;
        rr_next    = IDX_W'((int'(idx_q) + 1) % N_LIGHTS);
        skip_next  = idx_q;
        skip_found = 1'b0;
        j          = 0;
        for (int k = 1; k <= N_LIGHTS; k++) begin
            j = (int'(idx_q) + k) % N_LIGHTS;
            if (!skip_found && demand[IDX_W'(j)]) begin
                skip_found = 1'b1;
                skip_next  = IDX_W'(j);
            end
        end
    end

    // Next-state logic: flash overrides everything, go gates normal sequencing.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fl_ph_d      = fl_ph_q;
        turn_start_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        tmr_val      = '0;
        if (flash) begin
            if (state_q != ST_FLASH) begin
                state_d  = ST_FLASH;
                fl_ph_d  = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(T_FLASH - 1);
            end else begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    fl_ph_d  = ~fl_ph_q;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(T_FLASH - 1);
                end
            end
        end else if (state_q == ST_FLASH) begin
            state_d  = ST_ALLRED;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(T_ALLRED - 1);
        end else if (go) begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
                tmr_load = 1'b1;
                case (state_q)
                    ST_ALLRED: begin
                        if ((SKIP_EN != 0) && !skip_found) begin
                            tmr_val = TMR_W'(T_ALLRED - 1);
                        end else begin
                            state_d      = ST_RY;
                            idx_d        = (SKIP_EN != 0) ? skip_next : rr_next;
                            turn_start_d = 1'b1;
                            tmr_val      = TMR_W'(T_RY - 1);
                        end
                    end
                    ST_RY: begin
                        state_d = ST_GREEN;
                        tmr_val = TMR_W'(T_GREEN - 1);
                    end
                    ST_GREEN: begin
                        state_d = ST_YG;
                        tmr_val = TMR_W'(T_YG - 1);
                    end
                    default: begin
                        state_d = ST_ALLRED;
                        tmr_val = TMR_W'(T_ALLRED - 1);
                    end
                endcase
            end
        end
    end

    // State registers; reset aborts any phase straight into all-red.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ALLRED;
            idx_q        <= IDX_W'(N_LIGHTS - 1);
            fl_ph_q      <= 1'b0;
            turn_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fl_ph_q      <= fl_ph_d;
            turn_start_q <= turn_start_d;
        end
    end

    // Moore lamp decode: only the served light leaves red outside flash mode.
    always_comb begin
        sig  = '0;
        lamp = LAMP_R;
        for (int i = 0; i < N_LIGHTS; i++) begin
            lamp = LAMP_R;
            if (state_q == ST_FLASH) begin
                lamp = fl_ph_q ? LAMP_R : LAMP_YG;
            end else if (i == int'(idx_q)) begin
                case (state_q)
                    ST_RY:    lamp = LAMP_RY;
                    ST_GREEN: lamp = LAMP_G;
                    ST_YG:    lamp = LAMP_YG;
                    default:  lamp = LAMP_R;
                endcase
            end
            sig[2*i +: 2] = lamp;
        end
    end

    assign active     = idx_q;
    assign turn_start = turn_start_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench: two sequencer instances (plain round-robin with default
// timing, and demand-skipping on 3 lights with short phases) driven by shared
// directed and random stimulus, checked against a phase/remaining-cycle model.
module tb_traffic_phase_sequencer;

    localparam int PH_AR = 0;
    localparam int PH_RY = 1;
    localparam int PH_G  = 2;
    localparam int PH_YG = 3;
    localparam int PH_FL = 4;

    typedef struct {
        int phase;
        int left;
        int idx;
        bit fph;
        bit ts;
    } model_t;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] act;
        logic [15:0] ts;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       go;
    logic       flash;
    logic [3:0] demandA;
    logic [2:0] demandB;
    logic [7:0] sigA;
    logic [5:0] sigB;
    logic [1:0] actA;
    logic [1:0] actB;
    logic       tsA;
    logic       tsB;

    int checks;
    int errors;

    model_t mA;
    model_t mB;
    exp_t   qa[$];
    exp_t   qb[$];

    traffic_phase_sequencer #(
        .N_LIGHTS(4), .TMR_W(5), .T_ALLRED(1), .T_RY(2), .T_GREEN(30),
        .T_YG(2), .T_FLASH(1), .SKIP_EN(0)
    ) dutA (
        .clk(clk), .reset(reset), .go(go), .flash(flash), .demand(demandA),
        .sig(sigA), .active(actA), .turn_start(tsA)
    );

    traffic_phase_sequencer #(
        .N_LIGHTS(3), .TMR_W(3), .T_ALLRED(2), .T_RY(1), .T_GREEN(4),
        .T_YG(3), .T_FLASH(2), .SKIP_EN(1)
    ) dutB (
        .clk(clk), .reset(reset), .go(go), .flash(flash), .demand(demandB),
        .sig(sigB), .active(actB), .turn_start(tsB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference by one clock edge given that edge's inputs.
    function automatic model_t step(model_t m, int n, bit skip,
                                    int tar, int try_, int tg, int tyg, int tfl,
                                    bit r, bit g, bit f, logic [7:0] dem);
        model_t s;
        int pick;
        s = m;
        s.ts = 1'b0;
        pick = -1;
        if (r) begin
            s.phase = PH_AR; s.left = tar; s.idx = n - 1; s.fph = 1'b0;
        end else if (f) begin
            if (m.phase != PH_FL) begin
                s.phase = PH_FL; s.left = tfl; s.fph = 1'b0;
            end else begin
                s.left = m.left - 1;
                if (s.left == 0) begin
                    s.fph = !m.fph;
                    s.left = tfl;
                end
            end
        end else if (m.phase == PH_FL) begin
            s.phase = PH_AR; s.left = tar;
        end else if (g) begin
            s.left = m.left - 1;
            if (s.left == 0) begin
                case (m.phase)
                    PH_AR: begin
                        if (!skip) begin
                            pick = (m.idx + 1) % n;
                        end else begin
                            for (int k = 1; k <= n; k++) begin
                                if (pick < 0 && dem[(m.idx + k) % n]) pick = (m.idx + k) % n;
                            end
                        end
                        if (pick >= 0) begin
                            s.idx = pick; s.phase = PH_RY; s.left = try_; s.ts = 1'b1;
                        end else begin
                            s.left = tar;
                        end
                    end
                    PH_RY: begin s.phase = PH_G;  s.left = tg;  end
                    PH_G:  begin s.phase = PH_YG; s.left = tyg; end
                    default: begin s.phase = PH_AR; s.left = tar; end
                endcase
            end
        end
        return s;
    endfunction

    // Lamp picture and status the model predicts for its current phase.
    function automatic exp_t expect_of(model_t m, int n);
        exp_t e;
        logic [1:0] code;
        e.sig = '0;
        for (int i = 0; i < n; i++) begin
            code = 2'b10;
            if (m.phase == PH_FL) code = m.fph ? 2'b10 : 2'b01;
            else if (i == m.idx) begin
                case (m.phase)
                    PH_RY:   code = 2'b11;
                    PH_G:    code = 2'b00;
                    PH_YG:   code = 2'b01;
                    default: code = 2'b10;
                endcase
            end
            e.sig[2*i +: 2] = code;
        end
        e.act = 16'(m.idx);
        e.ts  = 16'(m.ts);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, actual, required);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit g, input bit f, input logic [7:0] d);
        reset   = r;
        go      = g;
        flash   = f;
        demandA = d[3:0];
        demandB = d[2:0];
        @(posedge clk);
        mA = step(mA, 4, 1'b0, 1, 2, 30, 2, 1, r, g, f, d);
        mB = step(mB, 3, 1'b1, 2, 1, 4, 3, 2, r, g, f, d);
        qa.push_back(expect_of(mA, 4));
        qb.push_back(expect_of(mB, 3));
        #1;
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                checkOutput("A.sig", 16'(sigA), e.sig);
                checkOutput("A.active", 16'(actA), e.act);
                checkOutput("A.turn_start", 16'(tsA), e.ts);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                checkOutput("B.sig", 16'(sigB), e.sig);
                checkOutput("B.active", 16'(actB), e.act);
                checkOutput("B.turn_start", 16'(tsB), e.ts);
            end
        end
    end

    initial begin
        int flLeft;
        checks = 0;
        errors = 0;
        flLeft = 0;
        mA = '{PH_AR, 1, 3, 1'b0, 1'b0};
        mB = '{PH_AR, 2, 2, 1'b0, 1'b0};
        reset = 1'b1; go = 1'b0; flash = 1'b0; demandA = '1; demandB = '1;

        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 8'hff);
        // Free run past a full 140-cycle round of the default instance.
        repeat (200) applyStimulus(1'b0, 1'b1, 1'b0, 8'hff);
        // Freeze mid-phase.
        repeat (7) applyStimulus(1'b0, 1'b0, 1'b0, 8'hff);
        repeat (30) applyStimulus(1'b0, 1'b1, 1'b0, 8'hff);
        // No demand, then single-light demand, then alternating demand.
        repeat (30) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (60) applyStimulus(1'b0, 1'b1, 1'b0, 8'h04);
        repeat (60) applyStimulus(1'b0, 1'b1, 1'b0, 8'h0a);
        // Flash episode and recovery.
        repeat (9) applyStimulus(1'b0, 1'b1, 1'b1, 8'hff);
        repeat (40) applyStimulus(1'b0, 1'b1, 1'b0, 8'hff);
        // Reset together with flash, then recovery.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hff);
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, 8'hff);
        // Random traffic: occasional resets, flash bursts, stalls, changing demand.
        for (int c = 0; c < 1500; c++) begin
            bit r;
            bit g;
            bit f;
            logic [7:0] d;
            r = ($urandom_range(0, 299) == 0);
            if (flLeft == 0 && $urandom_range(0, 149) == 0) flLeft = $urandom_range(1, 8);
            f = (flLeft > 0);
            if (flLeft > 0) flLeft--;
            g = ($urandom_range(0, 7) != 0);
            d = 8'($urandom);
            applyStimulus(r, g, f, d);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: actual=%0d required=0 pending expectations", qa.size() + qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
